// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle control FSM for an RV32I datapath (FETCH/DECODE/EXECUTE/MEM/WB).
// Ports:
//   clk, reset               - rising-edge clock, synchronous active-high reset
//   instrCode[31:0]          - instruction register, decoded from DECODE onward
//   dataMemReady             - data memory completion strobe (MEM stall release)
//   irWe, pcEn, regFileWe    - IR load, PC update, register file write enables
//   aluSrcMuxSel, aluControl - ALU operand B select (1 = imm) and operation
//   rfWdSrcMuxSel[2:0]       - writeback source: ALU/mem/imm/PC+imm/PC+4
//   branch, jal, jalr        - PC select qualifiers, EXECUTE only
//   dataMemReq, busWe        - memory request and write enable, MEM only
//   illegalInstr             - one-cycle pulse in DECODE for unknown opcodes
//   state[2:0]               - current FSM state for debug
module multi_cycle_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrCode,
    input  logic        dataMemReady,
    output logic        irWe,
    output logic        pcEn,
    output logic        regFileWe,
    output logic        aluSrcMuxSel,
    output logic [3:0]  aluControl,
    output logic [2:0]  rfWdSrcMuxSel,
    output logic        branch,
    output logic        jal,
    output logic        jalr,
    output logic        dataMemReq,
    output logic        busWe,
    output logic        illegalInstr,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4
    } state_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [2:0] WD_ALU  = 3'd0;
    localparam logic [2:0] WD_MEM  = 3'd1;
    localparam logic [2:0] WD_IMM  = 3'd2;
    localparam logic [2:0] WD_AUPC = 3'd3;
    localparam logic [2:0] WD_PC4  = 3'd4;

    state_e state_q;
    state_e state_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;

    assign opcode    = instrCode[6:0];
    assign funct3    = instrCode[14:12];
    assign funct7_b5 = instrCode[30];

    // Immediate/register fields are consumed by the datapath, not here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

    // ------------------------------------------------------------------
    // Opcode decode
    // ------------------------------------------------------------------
    logic is_r, is_i, is_l, is_s, is_b;
    logic is_lui, is_auipc, is_jal, is_jalr;
    logic is_legal;
    logic is_mem;
    logic writes_rd_ex;

    always_comb begin
        is_r     = 1'b0;
        is_i     = 1'b0;
        is_l     = 1'b0;
        is_s     = 1'b0;
        is_b     = 1'b0;
        is_lui   = 1'b0;
        is_auipc = 1'b0;
        is_jal   = 1'b0;
        is_jalr  = 1'b0;
        case (opcode)
            OP_R:     is_r     = 1'b1;
            OP_I:     is_i     = 1'b1;
            OP_L:     is_l     = 1'b1;
            OP_S:     is_s     = 1'b1;
            OP_B:     is_b     = 1'b1;
            OP_LUI:   is_lui   = 1'b1;
            OP_AUIPC: is_auipc = 1'b1;
            OP_JAL:   is_jal   = 1'b1;
            OP_JALR:  is_jalr  = 1'b1;
            default:  ;
        endcase
    end

    assign is_legal = is_r | is_i | is_l | is_s | is_b
                    | is_lui | is_auipc | is_jal | is_jalr;
    assign is_mem   = is_l | is_s;

    // Instructions that retire their rd write in EXECUTE (loads use WB).
    assign writes_rd_ex = is_r | is_i | is_lui | is_auipc | is_jal | is_jalr;

    // ------------------------------------------------------------------
    // Decode-derived datapath controls, held constant DECODE..last cycle
    // ------------------------------------------------------------------
    logic [3:0] alu_ctl_dec;
    logic       alu_src_dec;
    logic [2:0] wd_src_dec;

    always_comb begin
        alu_ctl_dec = 4'b0000;
        if (is_r) begin
            alu_ctl_dec = {funct7_b5, funct3};
        end else if (is_i) begin
            // Only SRLI/SRAI use bit 30; elsewhere it is immediate data.
            if (funct3 == 3'b101) begin
                alu_ctl_dec = {funct7_b5, funct3};
            end else begin
                alu_ctl_dec = {1'b0, funct3};
            end
        end else if (is_b) begin
            alu_ctl_dec = {1'b0, funct3};
        end
    end

    assign alu_src_dec = is_i | is_l | is_s | is_jalr;

    always_comb begin
        wd_src_dec = WD_ALU;
        if (is_l) begin
            wd_src_dec = WD_MEM;
        end else if (is_lui) begin
            wd_src_dec = WD_IMM;
        end else if (is_auipc) begin
            wd_src_dec = WD_AUPC;
        end else if (is_jal | is_jalr) begin
            wd_src_dec = WD_PC4;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: state_d = is_mem ? S_MEM : S_FETCH;
            S_MEM: begin
                if (!dataMemReady) begin
                    state_d = S_MEM;
                end else if (is_l) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB:      state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (Moore on state/instrCode; pcEn in MEM also sees ready)
    // ------------------------------------------------------------------
    always_comb begin
        irWe          = 1'b0;
        pcEn          = 1'b0;
        regFileWe     = 1'b0;
        aluSrcMuxSel  = 1'b0;
        aluControl    = 4'b0000;
        rfWdSrcMuxSel = WD_ALU;
        branch        = 1'b0;
        jal           = 1'b0;
        jalr          = 1'b0;
        dataMemReq    = 1'b0;
        busWe         = 1'b0;
        illegalInstr  = 1'b0;

        case (state_q)
            S_FETCH: begin
                irWe = 1'b1;
            end
            S_DECODE: begin
                aluSrcMuxSel  = alu_src_dec;
                aluControl    = alu_ctl_dec;
                rfWdSrcMuxSel = wd_src_dec;
                illegalInstr  = ~is_legal;
            end
            S_EXECUTE: begin
                aluSrcMuxSel  = alu_src_dec;
                aluControl    = alu_ctl_dec;
                rfWdSrcMuxSel = wd_src_dec;
                // Unknown opcodes also retire here, skipping the instruction.
                pcEn          = ~is_mem;
                regFileWe     = writes_rd_ex;
                branch        = is_b;
                jal           = is_jal;
                jalr          = is_jalr;
            end
            S_MEM: begin
                aluSrcMuxSel  = alu_src_dec;
                aluControl    = alu_ctl_dec;
                rfWdSrcMuxSel = wd_src_dec;
                dataMemReq    = 1'b1;
                busWe         = is_s;
                pcEn          = is_s & dataMemReady;
            end
            S_WB: begin
                aluSrcMuxSel  = alu_src_dec;
                aluControl    = alu_ctl_dec;
                rfWdSrcMuxSel = wd_src_dec;
                regFileWe     = 1'b1;
                pcEn          = 1'b1;
            end
            default: ;
        endcase

        // Reset quiets every control immediately, before the edge lands.
        if (reset) begin
            irWe          = 1'b0;
            pcEn          = 1'b0;
            regFileWe     = 1'b0;
            aluSrcMuxSel  = 1'b0;
            aluControl    = 4'b0000;
            rfWdSrcMuxSel = WD_ALU;
            branch        = 1'b0;
            jal           = 1'b0;
            jalr          = 1'b0;
            dataMemReq    = 1'b0;
            busWe         = 1'b0;
            illegalInstr  = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Directed bench for multi_cycle_control_unit.
// Stimulus queues per-cycle expected outputs; a negedge monitor compares them.
module tb_multi_cycle_control_unit;

    logic        clk;
    logic        reset;
    logic [31:0] instrCode;
    logic        dataMemReady;
    logic        irWe;
    logic        pcEn;
    logic        regFileWe;
    logic        aluSrcMuxSel;
    logic [3:0]  aluControl;
    logic [2:0]  rfWdSrcMuxSel;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        dataMemReq;
    logic        busWe;
    logic        illegalInstr;
    logic [2:0]  state;

    multi_cycle_control_unit dut (
        .clk           (clk),
        .reset         (reset),
        .instrCode     (instrCode),
        .dataMemReady  (dataMemReady),
        .irWe          (irWe),
        .pcEn          (pcEn),
        .regFileWe     (regFileWe),
        .aluSrcMuxSel  (aluSrcMuxSel),
        .aluControl    (aluControl),
        .rfWdSrcMuxSel (rfWdSrcMuxSel),
        .branch        (branch),
        .jal           (jal),
        .jalr          (jalr),
        .dataMemReq    (dataMemReq),
        .busWe         (busWe),
        .illegalInstr  (illegalInstr),
        .state         (state)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       ir;
        logic       pc;
        logic       rf;
        logic       asrc;
        logic [3:0] actl;
        logic [2:0] wd;
        logic       br;
        logic       jl;
        logic       jr;
        logic       rq;
        logic       bw;
        logic       il;
    } ov_t;

    typedef struct {
        string nm;
        ov_t   e;
    } sb_t;

    sb_t exp_q[$];
    int  n_chk;
    int  n_pass;
    ov_t act;

    assign act = {state, irWe, pcEn, regFileWe, aluSrcMuxSel, aluControl,
                  rfWdSrcMuxSel, branch, jal, jalr, dataMemReq, busWe,
                  illegalInstr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ov_t ev(
        input logic [2:0] s,
        input logic       ir, pc, rf, asrc,
        input logic [3:0] ac,
        input logic [2:0] wd,
        input logic       br, jl, jr, rq, bw, il
    );
        ov_t e;
        e.st = s;  e.ir = ir; e.pc = pc; e.rf = rf; e.asrc = asrc;
        e.actl = ac; e.wd = wd;
        e.br = br; e.jl = jl; e.jr = jr; e.rq = rq; e.bw = bw; e.il = il;
        return e;
    endfunction

    task automatic step(input logic rst, input logic [31:0] ins,
                        input logic rdy, input string nm, input ov_t e);
        sb_t it;
        @(posedge clk);
        #1;
        reset        = rst;
        instrCode    = ins;
        dataMemReady = rdy;
        it.nm = nm;
        it.e  = e;
        exp_q.push_back(it);
    endtask

    task automatic nonmem(input logic [31:0] ins, input string nm,
                          input logic asrc, input logic [3:0] ac,
                          input logic [2:0] wd, input logic rf,
                          input logic br, jl, jr, il);
        step(0, ins, 0, {nm, ".F"}, ev(0,1,0,0, 0,4'h0,3'd0, 0,0,0, 0,0,0));
        step(0, ins, 0, {nm, ".D"}, ev(1,0,0,0, asrc,ac,wd, 0,0,0, 0,0,il));
        step(0, ins, 0, {nm, ".E"}, ev(2,0,1,rf, asrc,ac,wd, br,jl,jr, 0,0,0));
    endtask

    always @(negedge clk) begin
        sb_t it;
        if (exp_q.size() != 0) begin
            it = exp_q.pop_front();
            n_chk++;
            if (act === it.e) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got %b required %b", it.nm, act, it.e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    localparam logic [31:0] LW = 32'h00402183;
    localparam logic [31:0] SW = 32'h00302423;

    initial begin
        n_chk        = 0;
        n_pass       = 0;
        reset        = 1'b1;
        instrCode    = 32'h0;
        dataMemReady = 1'b0;

        step(1, 32'h0, 0, "rst0", ev(0,0,0,0, 0,4'h0,3'd0, 0,0,0, 0,0,0));
        step(1, 32'h0, 1, "rst1", ev(0,0,0,0, 0,4'h0,3'd0, 0,0,0, 0,0,0));

        nonmem(32'h00208133, "add",    0, 4'b0000, 3'd0, 1, 0, 0, 0, 0);
        nonmem(32'h4030D093, "srai",   1, 4'b1101, 3'd0, 1, 0, 0, 0, 0);
        nonmem(32'h40008093, "addi30", 1, 4'b0000, 3'd0, 1, 0, 0, 0, 0);
        nonmem(32'h00209463, "bne",    0, 4'b0001, 3'd0, 0, 1, 0, 0, 0);
        nonmem(32'h123450B7, "lui",    0, 4'b0000, 3'd2, 1, 0, 0, 0, 0);
        nonmem(32'h00000097, "auipc",  0, 4'b0000, 3'd3, 1, 0, 0, 0, 0);
        nonmem(32'h008000EF, "jal",    0, 4'b0000, 3'd4, 1, 0, 1, 0, 0);
        nonmem(32'h000080E7, "jalr",   1, 4'b0000, 3'd4, 1, 0, 0, 1, 0);
        nonmem(32'h00000000, "ill",    0, 4'b0000, 3'd0, 0, 0, 0, 0, 1);

        // Load with two wait cycles: 7 cycles total.
        step(0, LW, 0, "lw.F",  ev(0,1,0,0, 0,4'h0,3'd0, 0,0,0, 0,0,0));
        step(0, LW, 0, "lw.D",  ev(1,0,0,0, 1,4'h0,3'd1, 0,0,0, 0,0,0));
        step(0, LW, 1, "lw.E",  ev(2,0,0,0, 1,4'h0,3'd1, 0,0,0, 0,0,0));
        step(0, LW, 0, "lw.M0", ev(3,0,0,0, 1,4'h0,3'd1, 0,0,0, 1,0,0));
        step(0, LW, 0, "lw.M1", ev(3,0,0,0, 1,4'h0,3'd1, 0,0,0, 1,0,0));
        step(0, LW, 1, "lw.M2", ev(3,0,0,0, 1,4'h0,3'd1, 0,0,0, 1,0,0));
        step(0, LW, 0, "lw.WB", ev(4,0,1,1, 1,4'h0,3'd1, 0,0,0, 0,0,0));

        // Store with ready already high everywhere: 4 cycles total.
        step(0, SW, 1, "sw.F",  ev(0,1,0,0, 0,4'h0,3'd0, 0,0,0, 0,0,0));
        step(0, SW, 1, "sw.D",  ev(1,0,0,0, 1,4'h0,3'd0, 0,0,0, 0,0,0));
        step(0, SW, 1, "sw.E",  ev(2,0,0,0, 1,4'h0,3'd0, 0,0,0, 0,0,0));
        step(0, SW, 1, "sw.M",  ev(3,0,1,0, 1,4'h0,3'd0, 0,0,0, 1,1,0));

        // Reset in the second MEM cycle of a load.
        step(0, LW, 0, "rl.F",  ev(0,1,0,0, 0,4'h0,3'd0, 0,0,0, 0,0,0));
        step(0, LW, 0, "rl.D",  ev(1,0,0,0, 1,4'h0,3'd1, 0,0,0, 0,0,0));
        step(0, LW, 0, "rl.E",  ev(2,0,0,0, 1,4'h0,3'd1, 0,0,0, 0,0,0));
        step(0, LW, 0, "rl.M0", ev(3,0,0,0, 1,4'h0,3'd1, 0,0,0, 1,0,0));
        step(1, LW, 1, "rl.M1", ev(3,0,0,0, 0,4'h0,3'd0, 0,0,0, 0,0,0));
        step(1, LW, 1, "rl.R",  ev(0,0,0,0, 0,4'h0,3'd0, 0,0,0, 0,0,0));
        nonmem(32'h00208133, "post", 0, 4'b0000, 3'd0, 1, 0, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control_unit.md
MULTI_CYCLE_CONTROL_UNIT -- requirements
Module: multi_cycle_control_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clk and reset are its clock and reset ports.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- instrCode  in  32  instruction register contents, valid from DECODE onward.
- dataMemReady  in  1  data memory completion strobe.
- irWe  out  1  instruction register load enable.
- pcEn  out  1  PC update enable.
- regFileWe  out  1  register file write enable.
- aluSrcMuxSel  out  1  0 = rs2, 1 = immediate.
- aluControl  out  4  ALU operation.
- rfWdSrcMuxSel  out  3  writeback source: 0 = ALU, 1 = memory, 2 = immediate, 3 = PC+imm, 4 = PC+4.
- branch  out  1  conditional PC select qualifier.
- jal  out  1  PC <- PC+imm.
- jalr  out  1  PC <- rs1+imm.
- dataMemReq  out  1  memory access request.
- busWe  out  1  memory write enable.
- illegalInstr  out  1  undecodable opcode pulse.
- state  out  3  current FSM state, for debug.

Function
REQ-003 The FSM SHALL have these states and encodings: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4. Encodings 5-7 SHALL go to FETCH on the next clock.
REQ-004 Opcodes SHALL be R=0110011, I=0010011, L=0000011, S=0100011, B=1100011, LUI=0110111, AUIPC=0010111, JAL=1101111, JALR=1100111.
REQ-005 Transitions SHALL be:
- FETCH -> DECODE unconditionally.
- DECODE -> EXECUTE.
- EXECUTE -> MEM for L/S; otherwise EXECUTE -> FETCH.
- MEM holds while dataMemReady=0. On dataMemReady=1, S -> FETCH and L -> WB.
- WB -> FETCH.
REQ-006 Instruction latencies SHALL be: 3 cycles for R/I/B/LUI/AUIPC/JAL/JALR, 4+w cycles for S, and 5+w cycles for L, where w = MEM wait cycles.
REQ-007 irWe SHALL be 1 only in FETCH.
REQ-008 pcEn SHALL be 1 exactly once per instruction, in its final cycle:
- EXECUTE for non-memory instructions.
- MEM with dataMemReady=1 for S.
- WB for L.
REQ-009 regFileWe SHALL be 1 in EXECUTE for R/I/LUI/AUIPC/JAL/JALR, in WB for L, and 0 otherwise.
REQ-010 dataMemReq SHALL be 1 throughout MEM. busWe SHALL equal dataMemReq for S and be 0 for L.
REQ-011 aluControl SHALL be:
- R: {instrCode[30], instrCode[14:12]}.
- I: {instrCode[30], funct3} if funct3=101, else {0, funct3}.
- B: {0, funct3}.
- All others: 0000 (ADD).
REQ-012 aluSrcMuxSel SHALL be 1 for I/L/S/JALR and 0 otherwise.
REQ-013 rfWdSrcMuxSel SHALL be 0 for R/I, 1 for L, 2 for LUI, 3 for AUIPC, 4 for JAL/JALR, and 0 otherwise.
REQ-014 branch, jal and jalr SHALL be 1 only in EXECUTE, for B, JAL and JALR respectively.
REQ-015 Decode-dependent outputs SHALL be 0 in FETCH. Opcode decode is valid from DECODE onward. aluControl and aluSrcMuxSel SHALL stay stable from DECODE through the instruction's last cycle.
REQ-016 An unrecognised opcode SHALL:
- pulse illegalInstr in DECODE;
- take EXECUTE with no regFileWe, dataMemReq or busWe;
- assert pcEn there, skipping the instruction.
REQ-017 All outputs SHALL be combinational from the state register and instrCode only. There SHALL be no combinational path from dataMemReady except to pcEn and the next state.

Reset
REQ-018 With reset=1 at a rising edge, state SHALL become FETCH regardless of the current state, including mid-MEM with dataMemReq=1.
REQ-019 While reset=1, all outputs except state SHALL be driven 0.
REQ-020 irWe SHALL first be 1 in the first cycle after reset deasserts.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- R-type: 0x00208133 (add x2,x1,x2) -> states 0,1,2. regFileWe=1 and pcEn=1 in cycle 3. aluControl=0000, aluSrcMuxSel=0, rfWdSrcMuxSel=0.
- Shift immediate: 0x4030D093 (srai x1,x1,3) -> aluControl=1101, aluSrcMuxSel=1, regFileWe=1 in EXECUTE.
- Load with wait: 0x00402183 (lw x3,4(x0)) and dataMemReady low for 2 MEM cycles -> MEM held 3 cycles with dataMemReq=1, busWe=0. WB follows with regFileWe=1, rfWdSrcMuxSel=1, pcEn=1. Total 7 cycles.
- Store, ready immediately: 0x00302423 (sw x3,8(x0)) -> 1 MEM cycle with dataMemReq=1, busWe=1, pcEn=1. Never regFileWe. Total 4 cycles.
- Illegal instruction: 0x00000000 -> illegalInstr=1 in DECODE. EXECUTE has pcEn=1, regFileWe=0, busWe=0.
- Reset mid-operation: reset asserted in the 2nd MEM cycle of a load -> next state=FETCH. All outputs 0 during reset. irWe=1 the cycle after release. No WB occurs.
